// File: rtl/lsu_mem_stage.sv
// RV32 MEM stage: runs the data-memory req/ack handshake, builds byte lanes,
// aligns and extends load data, and presents a registered write-back bundle.
module lsu_mem_stage #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_B,
  input  logic [2:0]  i_func3,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic [1:0]  o_lsu_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            is_mem, bad_op, misal, to_expire;

  logic [2:0]      func3_p0;
  logic [1:0]      addr_lo_p0;
  logic [4:0]      rd_p0;
  logic            reg_write_p0;
  logic            load_p0;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'd0:    lane_be = 4'b0001 << lo;
      2'd1:    lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] b);
    case (f3[1:0])
      2'd0:    lane_wdata = {4{b[7:0]}};
      2'd1:    lane_wdata = {2{b[15:0]}};
      default: lane_wdata = b;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rdata);
    logic [31:0]        byte_sh, half_sh;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_sh = rdata >> {lo, 3'b000};
    half_sh = rdata >> {lo[1], 4'b0000};
    byte_s  = byte_sh[7:0];
    half_s  = half_sh[15:0];
    case (f3)
      3'd0:    load_align = {{24{byte_s[7]}}, byte_s};
      3'd4:    load_align = {24'd0, byte_sh[7:0]};
      3'd1:    load_align = {{16{half_s[15]}}, half_s};
      3'd5:    load_align = {16'd0, half_sh[15:0]};
      default: load_align = rdata;
    endcase
  endfunction

  assign o_stall = (state == ACCESS);

  // Illegal-op and alignment checks take priority over issuing a request
  always_comb begin
    is_mem = i_mem_read | i_mem_write;
    bad_op = 1'b0;
    if (i_mem_read && i_mem_write)
      bad_op = 1'b1;
    else if (i_mem_write && (i_func3 > 3'd2))
      bad_op = 1'b1;
    else if (i_mem_read && !(i_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      bad_op = 1'b1;
    misal = 1'b0;
    if (is_mem) begin
      case (i_func3[1:0])
        2'd1:    misal = i_ALUOutput[0];
        2'd2:    misal = |i_ALUOutput[1:0];
        default: misal = 1'b0;
      endcase
    end
    to_expire = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid && is_mem && !bad_op && !misal) state_nxt = ACCESS;
      ACCESS:  if (i_dmem_ack || to_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Request capture (p0): context needed to finish the access
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_valid) begin
      func3_p0     <= i_func3;
      addr_lo_p0   <= i_ALUOutput[1:0];
      rd_p0        <= i_rd;
      reg_write_p0 <= i_reg_write;
      load_p0      <= i_mem_read;
    end
  end

  // Memory request and write-back bundle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      to_cnt       <= '0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= '0;
      o_dmem_wdata <= '0;
      o_valid      <= 1'b0;
      o_wb_data    <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_lsu_err    <= 2'b00;
    end else begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
      o_lsu_err   <= 2'b00;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (bad_op || misal || !is_mem) begin
              o_valid   <= 1'b1;
              o_wb_data <= i_ALUOutput;
              o_rd      <= i_rd;
              if (bad_op)     o_lsu_err   <= 2'b11;
              else if (misal) o_lsu_err   <= 2'b01;
              else            o_reg_write <= i_reg_write;
            end else begin
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= i_mem_write;
              o_dmem_addr  <= {i_ALUOutput[31:2], 2'b00};
              o_dmem_be    <= lane_be(i_func3, i_ALUOutput[1:0]);
              o_dmem_wdata <= lane_wdata(i_func3, i_B);
              to_cnt       <= '0;
            end
          end
        end
        ACCESS: begin
          if (i_dmem_ack) begin
            o_dmem_req  <= 1'b0;
            o_valid     <= 1'b1;
            o_rd        <= rd_p0;
            o_reg_write <= load_p0 & reg_write_p0;
            o_wb_data   <= load_p0 ? load_align(func3_p0, addr_lo_p0, i_dmem_rdata)
                                   : {o_dmem_addr[31:2], addr_lo_p0};
          end else if (to_expire) begin
            o_dmem_req <= 1'b0;
            o_valid    <= 1'b1;
            o_rd       <= rd_p0;
            o_wb_data  <= '0;
            o_lsu_err  <= 2'b10;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus pushes expected WB bundles,
// a monitor pops and compares on every o_valid.
module tb_lsu_mem_stage;

  localparam int ACK_TO = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_ALUOutput = '0;
  logic [31:0] i_B = '0;
  logic [2:0]  i_func3 = '0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic        i_reg_write = 1'b0;
  logic [4:0]  i_rd = '0;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic        o_stall, o_dmem_req, o_dmem_we, o_valid, o_reg_write;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_rd;
  logic [1:0]  o_lsu_err;

  always #5 i_clk = ~i_clk;

  lsu_mem_stage #(.ACK_TIMEOUT(ACK_TO), .TO_W(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_ALUOutput(i_ALUOutput),
    .i_B(i_B), .i_func3(i_func3), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_reg_write(i_reg_write), .i_rd(i_rd), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd(o_rd), .o_reg_write(o_reg_write),
    .o_lsu_err(o_lsu_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic cd, input logic [4:0] rd,
                      input logic rw, input logic [1:0] err);
    exp_t e;
    e.data = d; e.chk_data = cd; e.rd = rd; e.rw = rw; e.err = err;
    sb_q.push_back(e);
  endtask

  always @(negedge i_clk) begin
    if (i_reset && o_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got o_valid=1 rd=%0d data=0x%08h, required no completion",
                 o_rd, o_wb_data);
      end else begin
        mon_e = sb_q.pop_front();
        if ((mon_e.chk_data && o_wb_data !== mon_e.data) || o_rd !== mon_e.rd ||
            o_reg_write !== mon_e.rw || o_lsu_err !== mon_e.err) begin
          errors++;
          $display("FAIL wb_bundle: got data=0x%08h rd=%0d rw=%0b err=%0d, required data=0x%08h(chk=%0b) rd=%0d rw=%0b err=%0d",
                   o_wb_data, o_rd, o_reg_write, o_lsu_err,
                   mon_e.data, mon_e.chk_data, mon_e.rd, mon_e.rw, mon_e.err);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] b, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic rw, input logic [4:0] rd);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_ALUOutput = alu; i_B = b; i_func3 = f3;
    i_mem_read = mr; i_mem_write = mw; i_reg_write = rw; i_rd = rd;
  endtask

  task automatic idle_in();
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  // Starts in the first ACCESS cycle; acks in cycle n_ack (0 = never)
  task automatic mem_run(input int n_ack, input logic [31:0] rdata,
                         output int stall_n, output int req_n, output logic [31:0] addr,
                         output logic [3:0] be, output logic [31:0] wdata, output logic we);
    stall_n = 0; req_n = 0; addr = '0; be = '0; wdata = '0; we = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      i_dmem_ack = (c == n_ack);
      i_dmem_rdata = rdata;
      @(negedge i_clk);
      if (o_stall) stall_n++;
      if (o_dmem_req) req_n++;
      if (c == 1) begin
        addr = o_dmem_addr; be = o_dmem_be; wdata = o_dmem_wdata; we = o_dmem_we;
      end
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st, rq, acc;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we;

    #12;
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_req", 32'(o_dmem_req), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_wb_data", o_wb_data, 0);
    chk("rst_err", 32'(o_lsu_err), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;

    // ALU passthrough
    push(32'h5, 1'b1, 5'd3, 1'b1, 2'b00);
    drive(32'h0000_0005, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    idle_in();
    @(negedge i_clk);
    chk("add_valid", 32'(o_valid), 1);
    chk("add_stall", 32'(o_stall), 0);
    @(negedge i_clk);
    chk("add_single_pulse", 32'(o_valid), 0);

    // LB at 0x1003, ack in third ACCESS cycle
    push(32'hFFFF_FF80, 1'b1, 5'd5, 1'b1, 2'b00);
    drive(32'h0000_1003, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd5);
    idle_in();
    mem_run(3, 32'h80FF_1234, st, rq, a, be, wd, we);
    chk("lb_stall_cycles", st, 3);
    chk("lb_req_cycles", rq, 3);
    chk("lb_addr", a, 32'h0000_1000);
    chk("lb_be", 32'(be), 32'h8);
    chk("lb_we", 32'(we), 0);

    // LBU same scenario
    push(32'h0000_0080, 1'b1, 5'd5, 1'b1, 2'b00);
    drive(32'h0000_1003, 32'h0, 3'd4, 1'b1, 1'b0, 1'b1, 5'd5);
    idle_in();
    mem_run(3, 32'h80FF_1234, st, rq, a, be, wd, we);
    chk("lbu_stall_cycles", st, 3);

    // LH upper half, LHU lower half
    push(32'hFFFF_80FF, 1'b1, 5'd6, 1'b1, 2'b00);
    drive(32'h0000_1002, 32'h0, 3'd1, 1'b1, 1'b0, 1'b1, 5'd6);
    idle_in();
    mem_run(1, 32'h80FF_1234, st, rq, a, be, wd, we);
    chk("lh_be", 32'(be), 32'hC);
    push(32'h0000_1234, 1'b1, 5'd7, 1'b1, 2'b00);
    drive(32'h0000_1000, 32'h0, 3'd5, 1'b1, 1'b0, 1'b1, 5'd7);
    idle_in();
    mem_run(2, 32'h80FF_1234, st, rq, a, be, wd, we);
    chk("lhu_be", 32'(be), 32'h3);

    // SH at 0x2002
    push(32'h0, 1'b0, 5'd8, 1'b0, 2'b00);
    drive(32'h0000_2002, 32'hABCD_1234, 3'd1, 1'b0, 1'b1, 1'b1, 5'd8);
    idle_in();
    mem_run(1, 32'h0, st, rq, a, be, wd, we);
    chk("sh_addr", a, 32'h0000_2000);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wd, 32'h1234_1234);
    chk("sh_we", 32'(we), 1);

    // SB at 0x1001
    push(32'h0, 1'b0, 5'd0, 1'b0, 2'b00);
    drive(32'h0000_1001, 32'h0000_00AB, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle_in();
    mem_run(2, 32'h0, st, rq, a, be, wd, we);
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", wd, 32'hABAB_ABAB);

    // Reset while idle with non-zero held outputs
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("rst_idle_wb_data", o_wb_data, 0);
    chk("rst_idle_be", 32'(o_dmem_be), 0);
    chk("rst_idle_wdata", o_dmem_wdata, 0);
    chk("rst_idle_rd", 32'(o_rd), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;

    // Misaligned, illegal funct3, read+write both set
    push(32'h0, 1'b0, 5'd4, 1'b0, 2'b01);
    drive(32'h0000_2001, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd4);
    idle_in();
    @(negedge i_clk);
    chk("misal_valid", 32'(o_valid), 1);
    chk("misal_no_req", 32'(o_dmem_req), 0);
    chk("misal_no_stall", 32'(o_stall), 0);
    push(32'h0, 1'b0, 5'd2, 1'b0, 2'b11);
    drive(32'h0000_2000, 32'h0, 3'd3, 1'b0, 1'b1, 1'b1, 5'd2);
    idle_in();
    @(negedge i_clk);
    chk("sw_f3_no_req", 32'(o_dmem_req), 0);
    push(32'h0, 1'b0, 5'd1, 1'b0, 2'b11);
    drive(32'h0000_2000, 32'h0, 3'd2, 1'b1, 1'b1, 1'b1, 5'd1);
    idle_in();
    @(negedge i_clk);
    chk("rw_both_no_req", 32'(o_dmem_req), 0);

    // Ack in the same cycle as the timeout: ack wins
    push(32'hDEAD_BEEF, 1'b1, 5'd10, 1'b1, 2'b00);
    drive(32'h0000_5000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd10);
    idle_in();
    mem_run(ACK_TO, 32'hDEAD_BEEF, st, rq, a, be, wd, we);
    chk("ack_at_to_req", rq, ACK_TO);

    // Timeout, no ack
    push(32'h0, 1'b1, 5'd11, 1'b0, 2'b10);
    drive(32'h0000_3000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd11);
    idle_in();
    mem_run(0, 32'h0, st, rq, a, be, wd, we);
    chk("to_req_cycles", rq, ACK_TO);

    // Timeout with an ADD held upstream through the stall
    push(32'h0, 1'b1, 5'd12, 1'b0, 2'b10);
    push(32'h77, 1'b1, 5'd7, 1'b1, 2'b00);
    drive(32'h0000_6000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd12);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_ALUOutput = 32'h77; i_func3 = 3'd0;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_reg_write = 1'b1; i_rd = 5'd7;
    rq = 0; acc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      if (o_dmem_req) rq++;
      if (!o_stall) begin
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        acc = 1;
        break;
      end
    end
    chk("held_accepted", acc, 1);
    chk("held_to_req_cycles", rq, ACK_TO);
    @(negedge i_clk);
    chk("held_add_valid", 32'(o_valid), 1);

    // Reset mid-ACCESS, then a late ack
    drive(32'h0000_4000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd9);
    idle_in();
    @(negedge i_clk);
    chk("mid_req_high", 32'(o_dmem_req), 1);
    #2;
    i_reset = 1'b0;
    #1;
    chk("mid_rst_req_drop", 32'(o_dmem_req), 0);
    chk("mid_rst_stall", 32'(o_stall), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h1111_2222;
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    @(negedge i_clk);
    chk("late_ack_ignored", 32'(o_valid), 0);

    repeat (3) @(negedge i_clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
